word_lane_arbiter: RTL

//  Round-robin arbiter that shares one 8b->32b packer between NUM_LANES byte-stream requesters.

---
 rtl/word_lane_arbiter_if.sv | 32 +++
 rtl/word_lane_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/word_lane_arbiter_if.sv
// word_lane_arbiter_if
//  Bundle between NUM_LANES byte requesters, the lane arbiter and the packer.
//  master : requester/packer side (drives req_valid/req_data, sees the rest)
//  slave  : arbiter side
//   req_valid  per-lane byte valid          req_data  per-lane byte (lane i = [i])
//   req_ready  per-lane accept (comb)       grant     registered one-hot grant
//   data_out/valid_out/sel_out/word_start/word_end/pad_out : byte stream to packer
interface word_lane_arbiter_if #(
   parameter int NUM_LANES = 4,
   parameter int LANE_W    = 2
);
   logic [NUM_LANES-1:0]      req_valid;
   logic [NUM_LANES-1:0][7:0] req_data;
   logic [NUM_LANES-1:0]      req_ready;
   logic [NUM_LANES-1:0]      grant;
   logic [7:0]                data_out;
   logic                      valid_out;
   logic [LANE_W-1:0]         sel_out;
   logic                      word_start;
   logic                      word_end;
   logic                      pad_out;

   modport master (
      output req_valid, req_data,
      input  req_ready, grant, data_out, valid_out, sel_out, word_start, word_end, pad_out
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, grant, data_out, valid_out, sel_out, word_start, word_end, pad_out
   );
endinterface

// File: rtl/word_lane_arbiter.sv
// word_lane_arbiter
//  Round-robin arbiter sharing one byte->word packer between NUM_LANES byte lanes.
//  A lane keeps the grant for a whole word so words never mix lanes; a word
//  abandoned mid-way (MAX_GAP idle cycles) is completed with 0x00 pad bytes.
//  Ports:
//   clk_4f  byte-rate clock
//   reset   asynchronous, active-high
//   bus     word_lane_arbiter_if.slave (requests in, byte stream + grant out)
module word_lane_arbiter #(
   parameter int NUM_LANES      = 4,
   parameter int LANE_W         = 2,
   parameter int BYTES_PER_WORD = 4,
   parameter int MAX_GAP        = 8
) (
   input logic                clk_4f,
   input logic                reset,
   word_lane_arbiter_if.slave bus
);
   localparam int CNT_W = $clog2(BYTES_PER_WORD);
   localparam int STL_W = $clog2(MAX_GAP);
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);
   localparam logic [STL_W-1:0] STALL_MAX = STL_W'(MAX_GAP - 1);

   typedef enum logic [1:0] {IDLE, BUSY, PAD} state_t;

   state_t               state_q, state_nxt;
   logic [NUM_LANES-1:0] grant_q, grant_nxt;
   logic [LANE_W-1:0]    gidx_q, gidx_nxt;     // index of granted lane
   logic [LANE_W-1:0]    last_q, last_nxt;     // lane that finished the previous word
   logic [CNT_W-1:0]     bcnt_q, bcnt_nxt;
   logic [STL_W-1:0]     scnt_q, scnt_nxt;
   logic [7:0]           data_q, data_nxt;
   logic                 valid_q, valid_nxt;
   logic [LANE_W-1:0]    sel_q, sel_nxt;
   logic                 ws_q, ws_nxt;
   logic                 we_q, we_nxt;
   logic                 pad_q, pad_nxt;

   logic [LANE_W-1:0]    win;
   logic                 accept;

   assign bus.req_ready  = (state_q == BUSY) ? grant_q : '0;
   assign accept         = |(bus.req_valid & bus.req_ready);

   assign bus.grant      = grant_q;
   assign bus.data_out   = data_q;
   assign bus.valid_out  = valid_q;
   assign bus.sel_out    = sel_q;
   assign bus.word_start = ws_q;
   assign bus.word_end   = we_q;
   assign bus.pad_out    = pad_q;

   // Walk offsets from farthest to nearest so the nearest requester after
   // last_q is the one left in win.
   always_comb begin
      win = '0;
      for (int i = NUM_LANES; i >= 1; i--) begin
         if (bus.req_valid[(int'(last_q) + i) % NUM_LANES])
            win = LANE_W'((int'(last_q) + i) % NUM_LANES);
      end
   end

   always_comb begin
      state_nxt = state_q;
      grant_nxt = grant_q;
      gidx_nxt  = gidx_q;
      last_nxt  = last_q;
      bcnt_nxt  = bcnt_q;
      scnt_nxt  = scnt_q;
      data_nxt  = 8'h00;
      valid_nxt = 1'b0;
      sel_nxt   = '0;
      ws_nxt    = 1'b0;
      we_nxt    = 1'b0;
      pad_nxt   = 1'b0;
      case (state_q)
         IDLE: begin
            if (|bus.req_valid) begin
               grant_nxt = NUM_LANES'(1) << win;
               gidx_nxt  = win;
               bcnt_nxt  = '0;
               scnt_nxt  = '0;
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (accept) begin
               data_nxt  = bus.req_data[gidx_q];
               valid_nxt = 1'b1;
               sel_nxt   = gidx_q;
               ws_nxt    = (bcnt_q == '0);
               we_nxt    = (bcnt_q == LAST_BYTE);
               scnt_nxt  = '0;
               if (bcnt_q == LAST_BYTE) begin
                  bcnt_nxt  = '0;
                  last_nxt  = gidx_q;
                  grant_nxt = '0;
                  state_nxt = IDLE;
               end else begin
                  bcnt_nxt = bcnt_q + CNT_W'(1);
               end
            end else if (scnt_q == STALL_MAX) begin
               // Timed out: an untouched word is simply released, a partial
               // one is finished with pad bytes to keep the packer aligned.
               if (bcnt_q == '0) begin
                  grant_nxt = '0;
                  last_nxt  = gidx_q;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = PAD;
               end
            end else begin
               scnt_nxt = scnt_q + STL_W'(1);
            end
         end
         PAD: begin
            valid_nxt = 1'b1;
            pad_nxt   = 1'b1;
            sel_nxt   = gidx_q;
            we_nxt    = (bcnt_q == LAST_BYTE);
            if (bcnt_q == LAST_BYTE) begin
               bcnt_nxt  = '0;
               last_nxt  = gidx_q;
               grant_nxt = '0;
               state_nxt = IDLE;
            end else begin
               bcnt_nxt = bcnt_q + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_4f or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         gidx_q  <= '0;
         last_q  <= LANE_W'(NUM_LANES - 1);  // lane 0 first after reset
         bcnt_q  <= '0;
         scnt_q  <= '0;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         sel_q   <= '0;
         ws_q    <= 1'b0;
         we_q    <= 1'b0;
         pad_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         grant_q <= grant_nxt;
         gidx_q  <= gidx_nxt;
         last_q  <= last_nxt;
         bcnt_q  <= bcnt_nxt;
         scnt_q  <= scnt_nxt;
         data_q  <= data_nxt;
         valid_q <= valid_nxt;
         sel_q   <= sel_nxt;
         ws_q    <= ws_nxt;
         we_q    <= we_nxt;
         pad_q   <= pad_nxt;
      end
   end
endmodule
